// File: rtl/booth_mult_param_if.sv
// Shared operand/product bus for booth_mult_param: one W-bit operand bus in,
// one W-bit tagged product bus out, plus the start/ready handshake.
interface booth_mult_param_if #(
   parameter int W = 8
);
   logic [W-1:0] inbus;
   logic         start;
   logic         signed_mode;
   logic [W-1:0] outbus;
   logic         out_valid;
   logic         out_hi;
   logic         ready;

   modport master (
      output inbus, start, signed_mode,
      input  outbus, out_valid, out_hi, ready
   );

   modport slave (
      input  inbus, start, signed_mode,
      output outbus, out_valid, out_hi, ready
   );
endinterface

// File: rtl/booth_mult_param.sv
// Multi-cycle Booth multiplier (radix 2 or 4), signed/unsigned at run time.
// Operands arrive on consecutive cycles; the 2W-bit product leaves as two beats.
module booth_mult_param #(
   parameter int W     = 8,
   parameter int RADIX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   booth_mult_param_if.slave     bus
);
   // Two extra bits make unsigned operands look non-negative to the Booth recoder.
   localparam int M  = W + 2;
   localparam int AW = M + 2;
   localparam int S  = (RADIX == 2) ? 1 : 2;
   localparam int N  = (RADIX == 2) ? M : M / 2;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {IDLE, LOADY, CALC, OUTLO, OUTHI} state_t;

   state_t          state_reg, state_next;
   logic [M-1:0]    x_reg;
   logic [M-1:0]    y_reg;
   logic [AW-1:0]   a_reg;
   logic            yprev_reg;
   logic            mode_reg;
   logic [CW-1:0]   cnt_reg;

   logic [AW-1:0]   x_ext;
   logic [AW-1:0]   addend;
   logic signed [AW+M:0] cat;
   logic signed [AW+M:0] shifted;
   logic [2*W-1:0]  prod;

   function automatic logic [M-1:0] extend(input logic [W-1:0] v, input logic s);
      return {{(M-W){s & v[W-1]}}, v};
   endfunction

   assign x_ext = {{(AW-M){x_reg[M-1]}}, x_reg};

   generate
      if (RADIX == 2) begin : g_r2
         always_comb begin
            addend = '0;
            case ({y_reg[0], yprev_reg})
               2'b10:   addend = -x_ext;
               2'b01:   addend = x_ext;
               default: addend = '0;
            endcase
         end
      end else begin : g_r4
         logic [AW-1:0] x2;
         assign x2 = {x_ext[AW-2:0], 1'b0};
         always_comb begin
            addend = '0;
            case ({y_reg[1:0], yprev_reg})
               3'b001, 3'b010: addend = x_ext;
               3'b011:         addend = x2;
               3'b100:         addend = -x2;
               3'b101, 3'b110: addend = -x_ext;
               default:        addend = '0;
            endcase
         end
      end
   endgenerate

   assign cat     = {a_reg + addend, y_reg, yprev_reg};
   assign shifted = cat >>> S;
   assign prod    = (2*W)'({a_reg, y_reg});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = LOADY;
         LOADY:   state_next = CALC;
         CALC:    if (cnt_reg == CW'(1)) state_next = OUTLO;
         OUTLO:   state_next = OUTHI;
         OUTHI:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg     <= '0;
         y_reg     <= '0;
         a_reg     <= '0;
         yprev_reg <= 1'b0;
         mode_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  x_reg    <= extend(bus.inbus, bus.signed_mode);
                  mode_reg <= bus.signed_mode;
               end
            end
            LOADY: begin
               y_reg     <= extend(bus.inbus, mode_reg);
               a_reg     <= '0;
               yprev_reg <= 1'b0;
               cnt_reg   <= CW'(N);
            end
            CALC: begin
               a_reg     <= shifted[AW+M:M+1];
               y_reg     <= shifted[M:1];
               yprev_reg <= shifted[0];
               cnt_reg   <= cnt_reg - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset clears them at once.
   assign bus.ready     = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == OUTLO) || (state_reg == OUTHI);
   assign bus.out_hi    = (state_reg == OUTHI);
   assign bus.outbus    = (state_reg == OUTLO) ? prod[W-1:0] :
                          (state_reg == OUTHI) ? prod[2*W-1:W] : '0;
endmodule

// File: tb/tb_booth_mult_param.sv
// Self-checking bench: radix-4 and radix-2 instances driven in lockstep with
// directed vectors, a random regression and hand-written control sequences.
module tb_booth_mult_param;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   booth_mult_param_if #(.W(W)) bus4 ();
   booth_mult_param_if #(.W(W)) bus2 ();

   booth_mult_param #(.W(W), .RADIX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   booth_mult_param #(.W(W), .RADIX(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      bit         sm;
      logic [7:0] lo;
      logic [7:0] hi;
   } vec_t;
   vec_t vecs[10];

   logic [7:0] r_lo[2], r_hi[2];
   int         r_first[2], r_hicyc[2], r_nv[2];
   bit         r_rdy_end[2], r_busy_glitch[2];

   bit         s_rdy[2][31];
   bit         s_val[2][31];
   bit         s_hi[2][31];
   logic [7:0] s_out[2][31];

   function automatic int n_of(input int i);
      return (i == 0) ? 5 : 10;
   endfunction

   function automatic int rad_of(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit s, input logic [7:0] d, input bit sm);
      bus4.start = s; bus4.inbus = d; bus4.signed_mode = sm;
      bus2.start = s; bus2.inbus = d; bus2.signed_mode = sm;
   endtask

   task automatic get(input int i, output bit v, output bit h, output bit r,
                      output logic [7:0] o);
      if (i == 0) begin
         v = bus4.out_valid; h = bus4.out_hi; r = bus4.ready; o = bus4.outbus;
      end else begin
         v = bus2.out_valid; h = bus2.out_hi; r = bus2.ready; o = bus2.outbus;
      end
   endtask

   // Cycle c below is t0+c, where t0 is the cycle start is accepted in.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                         input bit sm, input bit glitch);
      bit v, h, r;
      logic [7:0] o;
      for (int i = 0; i < 2; i++) begin
         r_first[i] = -1; r_hicyc[i] = -1; r_nv[i] = 0;
         r_lo[i] = '0; r_hi[i] = '0; r_rdy_end[i] = 1'b0; r_busy_glitch[i] = 1'b0;
      end
      @(negedge clk);
      drive(1'b1, x, sm);
      @(negedge clk);
      drive(1'b0, y, ~sm);
      for (int c = 1; c <= 22; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 2) drive(1'b0, 8'h5A, sm);
         if (glitch && c == 4) drive(1'b1, ~x, ~sm);
         if (glitch && c == 5) drive(1'b0, 8'h00, sm);
         for (int i = 0; i < 2; i++) begin
            get(i, v, h, r, o);
            if (v) begin
               r_nv[i]++;
               if (!h) begin
                  if (r_first[i] < 0) r_first[i] = c;
                  r_lo[i] = o;
               end else begin
                  r_hicyc[i] = c;
                  r_hi[i] = o;
               end
            end
            if (c == 4)  r_busy_glitch[i] = !r;
            if (c == 22) r_rdy_end[i] = r;
         end
      end
   endtask

   task automatic check_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input bit sm, input bit glitch,
                           input logic [7:0] elo, input logic [7:0] ehi);
      for (int i = 0; i < 2; i++) begin
         string p;
         p = $sformatf("%s r%0d", tag, rad_of(i));
         check({p, " lo"}, int'(r_lo[i]), int'(elo));
         check({p, " hi"}, int'(r_hi[i]), int'(ehi));
         check({p, " lo_cycle"}, r_first[i], n_of(i) + 2);
         check({p, " hi_cycle"}, r_hicyc[i], n_of(i) + 3);
         check({p, " beats"}, r_nv[i], 2);
         check({p, " ready_after"}, int'(r_rdy_end[i]), 1);
         if (glitch) check({p, " busy_on_glitch"}, int'(r_busy_glitch[i]), 1);
      end
      $display("[TB] %s x=%h y=%h signed=%0d glitch=%0d r4=%h_%h r2=%h_%h exp=%h_%h",
               tag, x, y, sm, glitch, r_hi[0], r_lo[0], r_hi[1], r_lo[1], ehi, elo);
   endtask

   initial begin
      logic [7:0]  x, y;
      logic [31:0] pv;
      int          a, b, nv;
      bit          v, h, r, g;
      logic [7:0]  o;

      vecs[0] = '{8'hFD, 8'h05, 1'b1, 8'hF1, 8'hFF};
      vecs[1] = '{8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'h01, 8'h00};
      vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h00, 8'h40};
      vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h80, 8'hC0};
      vecs[5] = '{8'h00, 8'hA5, 1'b0, 8'h00, 8'h00};
      vecs[6] = '{8'h00, 8'hA5, 1'b1, 8'h00, 8'h00};
      vecs[7] = '{8'h7F, 8'h7F, 1'b1, 8'h01, 8'h3F};
      vecs[8] = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00};
      vecs[9] = '{8'h80, 8'hFF, 1'b0, 8'h80, 8'h7F};

      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         get(i, v, h, r, o);
         check($sformatf("reset r%0d ready", rad_of(i)), int'(r), 1);
         check($sformatf("reset r%0d out_valid", rad_of(i)), int'(v), 0);
         check($sformatf("reset r%0d out_hi", rad_of(i)), int'(h), 0);
         check($sformatf("reset r%0d outbus", rad_of(i)), int'(o), 0);
      end
      $display("[TB] reset state checked");
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         run_op(vecs[k].x, vecs[k].y, vecs[k].sm, k[0]);
         check_op($sformatf("vec%0d", k), vecs[k].x, vecs[k].y, vecs[k].sm, k[0],
                  vecs[k].lo, vecs[k].hi);
      end

      // start held high: back-to-back squares of 3, restart only once ready=1.
      @(negedge clk);
      drive(1'b1, 8'h03, 1'b1);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            get(i, s_val[i][c], s_hi[i][c], s_rdy[i][c], s_out[i][c]);
      end
      drive(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         int n;
         string p;
         n = n_of(i);
         p = $sformatf("held r%0d", rad_of(i));
         check({p, " lo1"}, int'({s_val[i][n+2], s_hi[i][n+2], s_out[i][n+2]}), int'({2'b10, 8'h09}));
         check({p, " ready_in_outhi"}, int'(s_rdy[i][n+3]), 0);
         check({p, " ready_gap"}, int'(s_rdy[i][n+4]), 1);
         check({p, " busy_again"}, int'(s_rdy[i][n+5]), 0);
         check({p, " lo2"}, int'({s_val[i][2*n+6], s_hi[i][2*n+6], s_out[i][2*n+6]}), int'({2'b10, 8'h09}));
      end
      $display("[TB] held start: r4 lo2=%h r2 lo2=%h exp=09", s_out[0][16], s_out[1][26]);
      repeat (40) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         get(i, v, h, r, o);
         check($sformatf("held r%0d drained", rad_of(i)), int'(r), 1);
      end

      // Reset mid-CALC: outputs must clear without waiting for a clock edge.
      @(negedge clk);
      drive(1'b1, 8'h77, 1'b1);
      @(negedge clk);
      drive(1'b0, 8'h33, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         get(i, v, h, r, o);
         check($sformatf("midreset r%0d ready", rad_of(i)), int'(r), 1);
         check($sformatf("midreset r%0d outbus", rad_of(i)), int'(o), 0);
         check($sformatf("midreset r%0d out_valid", rad_of(i)), int'(v), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            get(i, v, h, r, o);
            if (v) nv++;
         end
      end
      check("midreset stray beats", nv, 0);
      $display("[TB] reset mid-CALC: stray beats=%0d", nv);
      run_op(8'h7F, 8'h81, 1'b1, 1'b0);
      check_op("post_reset", 8'h7F, 8'h81, 1'b1, 1'b0, 8'hFF, 8'hC0);

      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 1000; k++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            g = ($urandom_range(0, 3) == 0);
            a = m[0] ? int'($signed(x)) : int'(x);
            b = m[0] ? int'($signed(y)) : int'(y);
            pv = 32'(a * b);
            run_op(x, y, m[0], g);
            check_op($sformatf("rand%0d_%0d", m, k), x, y, m[0], g, pv[7:0], pv[15:8]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
- Parametrised, multi-cycle Booth multiplier; next generation of the team's 6-bit shared-bus Booth multiplier.
- Generalised in operand width and Booth radix (2 or 4), with a run-time signed/unsigned mode.
- Operands are loaded over a single input bus on consecutive cycles. The 2W-bit product is returned over a W-bit output bus as two tagged beats.
- Sits beside other datapath units on the shared operand bus.

Parameters:
- W, 8, operand width in bits; must be even and ≥4.
- RADIX, 4, Booth radix; legal values are 2 or 4 only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- inbus  input  W  operand bus: X (multiplicand) on the start cycle, Y (multiplier) on the next cycle.
- start  input  1  begin operation; sampled only when ready=1.
- signed_mode  input  1  1=two's-complement operands, 0=unsigned; sampled with start.
- outbus  output  W  product beat; 0 when out_valid=0.
- out_valid  output  1  outbus holds a product beat.
- out_hi  output  1  0=low half [W-1:0], 1=high half [2W-1:W]; 0 when out_valid=0.
- ready  output  1  idle and able to accept start.

Behaviour:
- States: IDLE, LOADY, CALC, OUTLO, OUTHI.
- Reset (async, any state):
  - state=IDLE; all registers cleared.
  - ready=1; out_valid=0; out_hi=0; outbus=0.
- IDLE:
  - ready=1.
  - On start=1: latch X=inbus and mode=signed_mode; go to LOADY.
  - start=0: remain in IDLE.
- LOADY (ready=0):
  - Latch Y=inbus.
  - Clear accumulator A; load iteration counter with N.
  - Go to CALC.
- Internal width M=W+2:
  - X and Y are extended to M bits: sign-extended if mode=1, zero-extended if mode=0.
  - This guarantees exact unsigned results for both radices.
  - A is M+2 bits wide so radix-4 ±2X never overflows.
- CALC, one Booth step per cycle:
  - RADIX=2:
    - Examine {Y0, Yprev}: 10 → A−=X; 01 → A+=X; 00/11 → no-op.
    - Then arithmetic right shift of {A,Y,Yprev} by 1.
    - N=M.
  - RADIX=4:
    - Examine {Y1, Y0, Yprev}: 000/111 → 0; 001/010 → +X; 011 → +2X; 100 → −2X; 101/110 → −X.
    - Then arithmetic right shift by 2.
    - N=M/2.
  - Counter decrements each step. Leave CALC after step N completes (counter 1→0); go to OUTLO.
- Product P: low 2W bits of the final {A,Y} concatenation. Must equal X*Y mod 2^(2W) under the latched mode.
- OUTLO (one cycle): outbus=P[W-1:0]; out_valid=1; out_hi=0.
- OUTHI (one cycle): outbus=P[2W-1:W]; out_valid=1; out_hi=1; then go to IDLE.
- Latency: start accepted at edge t0.
  - LOADY occupies cycle t0+1.
  - CALC occupies cycles t0+2 … t0+1+N.
  - OUTLO is at t0+2+N; OUTHI at t0+3+N; ready=1 again at t0+4+N.
  - W=8: RADIX=4 gives N=5, OUTLO at t0+7. RADIX=2 gives N=10, OUTLO at t0+12.
- Boundary conditions:
  - start while ready=0: ignored; no effect on the in-flight operation.
  - inbus and signed_mode: don't-care outside the IDLE-start cycle and the LOADY cycle.
  - start asserted in the same cycle OUTHI returns to IDLE: ignored, because ready=0 that cycle.
  - start held high continuously: a new operation begins on the first cycle ready=1.
  - Reset mid-CALC or mid-output: immediate return to IDLE; the partial product is discarded and no further out_valid beats appear.
  - Most-negative operand (−2^(W-1)) in signed mode: must be exact, no overflow.
- No back-pressure: the consumer must accept both beats on the cycles presented.

Test Plan:
- W=8, RADIX=4, signed: X=0xFD (−3), Y=0x05 → OUTLO outbus=0xF1, OUTHI outbus=0xFF (−15); out_valid exactly 2 cycles; OUTLO at t0+7.
- Unsigned: X=0xFF, Y=0xFF → beats 0x01 then 0xFE (65025). The same operands in signed mode → 0x01 then 0x00 (+1).
- Signed: X=0x80, Y=0x80 → 0x00 then 0x40 (16384). Signed: X=0x80, Y=0x7F → 0x80 then 0xC0 (−16256).
- Zero operand: X=0x00, Y=0xA5 in both modes → 0x00, 0x00. Random regression of 1000 operand pairs per mode, with RADIX=2 and RADIX=4, checked against a reference multiply; verify that the RADIX=2 OUTLO lands at t0+12.
- Control robustness:
  - Pulse start with a different inbus during CALC → result unchanged; ready stays 0.
  - Assert rst mid-CALC → ready=1 and outbus=0 immediately with no clock edge; no out_valid afterward.
  - A fresh operation after reset completes correctly.
